memsplit_data_arb: RTL and testbench

Two-master arbiter for the data-side port of the split-memory bus unit. It merges the debug-host bus and the CPU data bus onto one slave port. It records the source of every accepted read in an in-order tag FIFO, so each read response is routed back to the master that issued it. It sits between the UART debug master / CPU data port and the bus unit's bus1 slave, and replaces the untracked combinational mux with bounded, checked response routing.

---
 rtl/memsplit_data_arb.sv | 146 ++++++++++++++
 tb/tb_memsplit_data_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memsplit_data_arb.sv
// memsplit_data_arb: two-master arbiter for the data-side bus1 slave port.
// Merges the debug host (m0) and CPU data (m1) onto one slave and routes
// each in-order read response back to its issuer via a 1-bit tag FIFO.
//
// Ports:
//   clk_i, srst             clock, synchronous active-high reset
//   m0_* / m1_*             master request in (req/we/addr/be/wdata),
//                           accept/response out (ack/resp/rdata)
//   s_*                     slave request out, accept/response in
//   err_o                   sticky: response seen with no read outstanding
//
// Build option: define MEMSPLIT_ARB_RR_EN for round-robin arbitration
// (default is fixed priority, m0 first).
module memsplit_data_arb #(
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        srst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_resp,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_resp,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic        s_resp,
    input  logic [31:0] s_rdata,

    output logic        err_o
);

    localparam int PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RD_FIFO_DEPTH);

    logic [RD_FIFO_DEPTH-1:0] tag_q;
    logic [PW-1:0]            wptr_q;
    logic [PW-1:0]            rptr_q;
    logic [CW-1:0]            cnt_q;
    logic                     err_q;

    logic any_req;
    logic gnt_id;
    logic g_we;
    logic full;
    logic empty;
    logic issue;
    logic accept;
    logic push;
    logic pop;
    logic head;
    logic route;

`ifdef MEMSPLIT_ARB_RR_EN
    logic last_q;

    // On a tie the master that did not win the last accepted transfer wins.
    assign gnt_id = (m0_req & m1_req) ? ~last_q : ~m0_req;
`else
    assign gnt_id = ~m0_req;
`endif

    assign any_req = (m0_req | m1_req) & ~srst;
    assign g_we    = gnt_id ? m1_we : m0_we;
    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);

    // A read blocked by a full tag FIFO stalls the port; the other
    // master is deliberately not granted in its place.
    assign issue   = any_req & (g_we | ~full);
    assign accept  = issue & s_ack;
    assign push    = accept & ~g_we;
    assign pop     = s_resp & ~empty & ~srst;

    assign s_req   = issue;
    assign s_we    = issue & g_we;
    assign s_addr  = issue ? (gnt_id ? m1_addr  : m0_addr)  : '0;
    assign s_be    = issue ? (gnt_id ? m1_be    : m0_be)    : '0;
    assign s_wdata = issue ? (gnt_id ? m1_wdata : m0_wdata) : '0;

    assign m0_ack  = accept & ~gnt_id;
    assign m1_ack  = accept &  gnt_id;

    assign head    = tag_q[rptr_q];
    assign route   = ~empty & ~srst;

    assign m0_resp  = pop & ~head;
    assign m1_resp  = pop &  head;
    assign m0_rdata = (route & ~head) ? s_rdata : '0;
    assign m1_rdata = (route &  head) ? s_rdata : '0;

    assign err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (srst) begin
            tag_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wptr_q] <= gnt_id;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            // Same-cycle response to a fresh accept still counts as
            // unexpected: the FIFO is judged on its registered state.
            if (s_resp && empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef MEMSPLIT_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (srst) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= gnt_id;
        end
    end
`endif

endmodule

// File: tb/tb_memsplit_data_arb.sv
// tb_memsplit_data_arb: directed + random checks of memsplit_data_arb
// against a queue-based reference model of the arbiter rules.
module tb_memsplit_data_arb;

    localparam int D = 4;

    logic        clk_i = 1'b0;
    logic        srst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_resp, m1_ack, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack, s_resp;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    bit q[$];
    bit err_m  = 1'b0;
    bit last_m = 1'b0;

    always #5 clk_i = ~clk_i;

    memsplit_data_arb #(.RD_FIFO_DEPTH(D)) dut (
        .clk_i(clk_i), .srst(srst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
        .s_be(s_be), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r0, input logic w0,
                       input logic [31:0] a0,
                       input logic r1, input logic w1,
                       input logic [31:0] a1,
                       input logic ack, input logic resp,
                       input logic [31:0] rd);
        m0_req = r0; m0_we = w0; m0_addr = a0;
        m1_req = r1; m1_we = w1; m1_addr = a1;
        m0_be = 4'($urandom); m1_be = 4'($urandom);
        m0_wdata = $urandom; m1_wdata = $urandom;
        s_ack = ack; s_resp = resp; s_rdata = rd;
    endtask

    // Check every output against the model, advance the model, and
    // move to the next negative edge where new inputs are applied.
    task automatic cyc();
        bit        win, wwe, go, acc;
        bit [31:0] e_addr, e_wd;
        bit [3:0]  e_be;
        bit        e_r0, e_r1;
        bit [31:0] e_d0, e_d1;
        #1;
        if (!m0_req && !m1_req) win = 1'b0;
        else if (m0_req && !m1_req) win = 1'b0;
        else if (!m0_req && m1_req) win = 1'b1;
`ifdef MEMSPLIT_ARB_RR_EN
        else win = (last_m == 1'b0);
`else
        else win = 1'b0;
`endif
        wwe = win ? m1_we : m0_we;
        go  = !srst && (m0_req || m1_req) && (wwe || q.size() < D);
        acc = go && s_ack;
        e_addr = go ? (win ? m1_addr : m0_addr) : 32'h0;
        e_be   = go ? (win ? m1_be : m0_be) : 4'h0;
        e_wd   = go ? (win ? m1_wdata : m0_wdata) : 32'h0;
        e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0;
        if (!srst && q.size() > 0) begin
            if (q[0]) begin e_r1 = s_resp; e_d1 = s_rdata; end
            else      begin e_r0 = s_resp; e_d0 = s_rdata; end
        end
        chk("s_req",    32'(s_req),   32'(go));
        chk("s_we",     32'(s_we),    32'(go && wwe));
        chk("s_addr",   s_addr,       e_addr);
        chk("s_be",     32'(s_be),    32'(e_be));
        chk("s_wdata",  s_wdata,      e_wd);
        chk("m0_ack",   32'(m0_ack),  32'(acc && !win));
        chk("m1_ack",   32'(m1_ack),  32'(acc && win));
        chk("m0_resp",  32'(m0_resp), 32'(e_r0));
        chk("m1_resp",  32'(m1_resp), 32'(e_r1));
        chk("m0_rdata", m0_rdata,     e_d0);
        chk("m1_rdata", m1_rdata,     e_d1);
        chk("err_o",    32'(err_o),   32'(err_m));
        if (srst) begin
            q.delete();
            err_m  = 1'b0;
            last_m = 1'b0;
        end else begin
            if (s_resp) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1'b1;
            end
            if (acc) begin
                if (!wwe) q.push_back(win);
                last_m = win;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        srst = 1'b1;
        cyc();
        cyc();
        srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        cyc();
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_sreq", 32'(s_req), 32'h0);
        srst = 1'b0;

        // Simultaneous write (m0) and read (m1), response to m1.
        drv(1, 1, 32'h10, 1, 0, 32'h20, 1, 0, 0);
        #1;
`ifndef MEMSPLIT_ARB_RR_EN
        chk("tp1_m0ack", 32'(m0_ack), 32'h1);
        chk("tp1_m1ack", 32'(m1_ack), 32'h0);
        chk("tp1_addr", s_addr, 32'h10);
`endif
        cyc();
        drv(0, 0, 0, 1, 0, 32'h20, 1, 0, 0);
        #1;
        chk("tp1_m1acc", 32'(m1_ack), 32'h1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        #1;
        chk("tp1_m1resp", 32'(m1_resp), 32'h1);
        chk("tp1_m1rd", m1_rdata, 32'hDEADBEEF);
        chk("tp1_m0resp", 32'(m0_resp), 32'h0);
        chk("tp1_m0rd", m0_rdata, 32'h0);
        cyc();

        // Interleaved reads, in-order routing.
        do_reset();
        drv(0, 0, 0, 1, 0, 32'h0, 1, 0, 0); cyc();
        drv(1, 0, 32'h4, 0, 0, 0, 1, 0, 0); cyc();
        drv(0, 0, 0, 1, 0, 32'h8, 1, 0, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hA);
        #1;
        chk("tp2_a", m1_rdata, 32'hA);
        chk("tp2_a_m0", 32'(m0_resp), 32'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
        #1;
        chk("tp2_b", m0_rdata, 32'hB);
        chk("tp2_b_m1", 32'(m1_resp), 32'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'hC);
        #1;
        chk("tp2_c", 32'(m1_resp), 32'h1);
        chk("tp2_c_m0", 32'(m0_resp), 32'h0);
        cyc();

        // Full FIFO gates reads, not writes; pop unblocks next cycle.
        do_reset();
        for (int i = 0; i < D; i++) begin
            drv(1, 0, 32'(i * 4), 0, 0, 0, 1, 0, 0);
            cyc();
        end
        drv(1, 0, 32'h40, 0, 0, 0, 1, 0, 0);
        #1;
        chk("tp3_sreq", 32'(s_req), 32'h0);
        chk("tp3_ack", 32'(m0_ack), 32'h0);
        cyc();
        drv(1, 0, 32'h40, 1, 1, 32'h80, 1, 0, 0);
        #1;
        chk("tp3_noswap", 32'(m1_ack), 32'h0);
        cyc();
        drv(0, 0, 0, 1, 1, 32'h80, 1, 0, 0);
        #1;
        chk("tp3_wr", 32'(m1_ack), 32'h1);
        cyc();
        drv(1, 0, 32'h40, 0, 0, 0, 1, 1, 32'h5);
        #1;
        chk("tp3_popblk", 32'(m0_ack), 32'h0);
        chk("tp3_resp", 32'(m0_resp), 32'h1);
        cyc();
        drv(1, 0, 32'h40, 0, 0, 0, 1, 0, 0);
        #1;
        chk("tp3_unblk", 32'(m0_ack), 32'h1);
        cyc();

        // Unexpected response sets sticky error.
        do_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        #1;
        chk("tp4_r0", 32'(m0_resp), 32'h0);
        chk("tp4_r1", 32'(m1_resp), 32'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("tp4_err", 32'(err_o), 32'h1);
            cyc();
        end

        // Reset with reads outstanding drops tags.
        do_reset();
        chk("tp5_err0", 32'(err_o), 32'h0);
        drv(1, 0, 32'h0, 0, 0, 0, 1, 0, 0); cyc();
        drv(0, 0, 0, 1, 0, 32'h4, 1, 0, 0); cyc();
        srst = 1'b1;
        drv(1, 0, 32'h8, 1, 0, 32'hC, 1, 0, 0);
        #1;
        chk("tp5_sreq", 32'(s_req), 32'h0);
        chk("tp5_ack", 32'(m0_ack | m1_ack), 32'h0);
        cyc();
        srst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
        #1;
        chk("tp5_resp", 32'(m0_resp | m1_resp), 32'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("tp5_err", 32'(err_o), 32'h1);
        cyc();

        // Tie arbitration over consecutive cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 32'h100, 1, 1, 32'h200, 1, 0, 0);
            #1;
`ifdef MEMSPLIT_ARB_RR_EN
            chk("tp6_rr", 32'(m1_ack), 32'((i % 2) == 0));
`else
            chk("tp6_fix", 32'(m0_ack), 32'h1);
`endif
            cyc();
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            srst = ($urandom_range(0, 99) < 3);
            drv($urandom_range(0, 9) < 6, 1'($urandom),
                $urandom, $urandom_range(0, 9) < 6, 1'($urandom),
                $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 4, $urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
